// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared types and parameter legality checks for the lfsr_prng generator.
//   lfsr_mode_e : feedback structure (FIB = Fibonacci, GAL = Galois)
//   lfsr_fsm_e  : controller states (S_IDLE, S_WARM, S_RUN)
//   *_ok()      : elaboration-time parameter checks used by lfsr_prng
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic {
        FIB = 1'b0,
        GAL = 1'b1
    } lfsr_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2
    } lfsr_fsm_e;

    // Warm-up counter is 8 bits wide.
    localparam int MAX_WARMUP = 255;

    function automatic bit width_ok(input int width);
        return width >= 3;
    endfunction

    function automatic bit mode_ok(input int mode);
        return (mode == int'(FIB)) || (mode == int'(GAL));
    endfunction

    function automatic bit steps_ok(input int width, input int steps);
        return (steps >= 1) && (steps <= width);
    endfunction

    function automatic bit warmup_ok(input int warmup);
        return (warmup >= 0) && (warmup <= MAX_WARMUP);
    endfunction

    // A Galois mask without bit 0 set cannot feed the shifted-out MSB back
    // into the register, so the sequence collapses.
    function automatic bit gmask_ok(input int mode, input bit gmask_lsb);
        return (mode != int'(GAL)) || gmask_lsb;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// Purely combinational single LFSR shift.
//   cur  (in,  WIDTH) : current state
//   nxt  (out, WIDTH) : state after one shift
// MODE selects Fibonacci (feedback = XOR of TAPS-selected bits, shifted in at
// bit 0) or Galois (GMASK XORed in whenever the MSB shifts out).
// -----------------------------------------------------------------------------
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               MODE  = 0,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] GMASK = 8'h1D
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    localparam bit IS_GAL = (MODE == int'(GAL));

    logic             fib_fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;

    assign fib_fb   = ^(cur & TAPS);
    assign fib_next = {cur[WIDTH-2:0], fib_fb};
    assign gal_next = {cur[WIDTH-2:0], 1'b0} ^ ({WIDTH{cur[WIDTH-1]}} & GMASK);

    assign nxt = IS_GAL ? gal_next : fib_next;

endmodule

// File: rtl/lfsr_prng.sv
// -----------------------------------------------------------------------------
// lfsr_prng
// Parametrised LFSR pseudo-random word generator with seed load, zero-lockup
// protection, optional warm-up and a valid/ready output stream.
//
// Ports:
//   clk         (in)          clock
//   reset       (in)          asynchronous, active-high reset
//   seed_valid  (in)          load seed this cycle (always accepted)
//   seed        (in,  WIDTH)  seed value; all-zero is replaced by DEFAULT_SEED
//   out_valid   (out)         out_data holds a valid word
//   out_ready   (in)          consumer accepts the current word
//   out_data    (out, WIDTH)  current LFSR state
//   busy        (out)         high while warm-up words are being discarded
//   period_done (out)         only with LFSR_PERIOD_CHECK_EN: one-cycle pulse
//                             when an accept returns the state to the seed
//
// Optional feature macro: LFSR_PERIOD_CHECK_EN (period counter, period_done
// port and period_len debug register).
// -----------------------------------------------------------------------------
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               MODE         = 0,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0] GMASK        = 8'h1D,
    parameter int               STEPS        = 1,
    parameter int               WARMUP       = 0,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef LFSR_PERIOD_CHECK_EN
    ,
    output logic             period_done
`endif
);

    // ---------------------------------------------------------------- checks
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("lfsr_prng: WIDTH must be >= 3");
    end
    if (!mode_ok(MODE)) begin : g_bad_mode
        $error("lfsr_prng: MODE must be 0 (Fibonacci) or 1 (Galois)");
    end
    if (!steps_ok(WIDTH, STEPS)) begin : g_bad_steps
        $error("lfsr_prng: STEPS must be in 1..WIDTH");
    end
    if (!warmup_ok(WARMUP)) begin : g_bad_warmup
        $error("lfsr_prng: WARMUP must be in 0..255");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
        $error("lfsr_prng: DEFAULT_SEED must be nonzero");
    end
    if (!gmask_ok(MODE, GMASK[0])) begin : g_bad_gmask
        $error("lfsr_prng: GMASK[0] must be 1 in Galois mode");
    end

    // ------------------------------------------------------------- datapath
    logic [WIDTH-1:0] state_reg;
    lfsr_fsm_e        fsm_reg;
    logic [7:0]       warm_cnt_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] seed_sub;
    logic             state_zero;

    // STEPS single shifts chained combinationally; each stage lives in its
    // own generate scope so the chain is a plain feed-forward net list.
    genvar gi;
    for (gi = 0; gi < STEPS; gi++) begin : g_step
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_out;
        if (gi == 0) begin : g_first
            assign s_in = state_reg;
        end else begin : g_link
            assign s_in = g_step[gi-1].s_out;
        end
        lfsr_step #(
            .WIDTH (WIDTH),
            .MODE  (MODE),
            .TAPS  (TAPS),
            .GMASK (GMASK)
        ) u_step (
            .cur (s_in),
            .nxt (s_out)
        );
    end
    assign stepped = g_step[STEPS-1].s_out;

    assign seed_sub   = (seed == '0) ? DEFAULT_SEED : seed;
    assign state_zero = (state_reg == '0);

    // ------------------------------------------------------------------ FSM
    // A seed load wins over everything else in the same cycle, including an
    // accept: the accepted word is the pre-load value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= DEFAULT_SEED;
            fsm_reg       <= S_IDLE;
            warm_cnt_reg  <= 8'd0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (seed_valid) begin
            state_reg <= seed_sub;
            if (WARMUP > 0) begin
                warm_cnt_reg  <= 8'(WARMUP);
                fsm_reg       <= S_WARM;
                out_valid_reg <= 1'b0;
                busy_reg      <= 1'b1;
            end else begin
                fsm_reg       <= S_RUN;
                out_valid_reg <= 1'b1;
                busy_reg      <= 1'b0;
            end
        end else begin
            case (fsm_reg)
                S_IDLE: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
                S_WARM: begin
                    state_reg    <= state_zero ? DEFAULT_SEED : stepped;
                    warm_cnt_reg <= warm_cnt_reg - 8'd1;
                    if (warm_cnt_reg == 8'd1) begin
                        fsm_reg       <= S_RUN;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (state_zero) begin
                        state_reg <= DEFAULT_SEED;
                    end else if (out_ready) begin
                        state_reg <= stepped;
                    end
                end
                default: begin
                    fsm_reg       <= S_IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign out_data  = state_reg;

`ifdef LFSR_PERIOD_CHECK_EN
    // Counts accepted words since the last seed load (or last completed
    // period); the compare is against the seed after zero substitution.
    logic [WIDTH+7:0] step_cnt_reg;
    logic [WIDTH+7:0] period_len_reg;
    logic [WIDTH-1:0] loaded_seed_reg;
    logic             period_done_reg;
    logic             accept;

    assign accept = out_valid_reg && out_ready && !seed_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt_reg    <= '0;
            period_len_reg  <= '0;
            loaded_seed_reg <= DEFAULT_SEED;
            period_done_reg <= 1'b0;
        end else begin
            period_done_reg <= 1'b0;
            if (seed_valid) begin
                step_cnt_reg    <= '0;
                loaded_seed_reg <= seed_sub;
            end else if (accept) begin
                if (stepped == loaded_seed_reg) begin
                    period_done_reg <= 1'b1;
                    period_len_reg  <= step_cnt_reg + (WIDTH+8)'(1);
                    step_cnt_reg    <= '0;
                end else begin
                    step_cnt_reg <= step_cnt_reg + (WIDTH+8)'(1);
                end
            end
        end
    end

    assign period_done = period_done_reg;
`endif

    // Seed substitution keeps the register out of the all-zero lockup state.
    a_no_lockup: assert property (@(posedge clk) disable iff (reset)
                                  (state_reg != '0));

endmodule

// File: tb/tb_lfsr_prng.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prng
// Three generators run side by side from shared seed_valid/out_ready:
//   inst 0: defaults (Fibonacci, TAPS B8)
//   inst 1: Galois, GMASK 1D
//   inst 2: Fibonacci with WARMUP = 3
// A reference model (GF(2) arithmetic on integers) predicts every output each
// cycle; directed literal checks pin the model to known words and periods.
// -----------------------------------------------------------------------------
module tb_lfsr_prng;

    localparam int N = 3;
    localparam int MODE_OF [N] = '{0, 1, 0};
    localparam int WARM_OF [N] = '{0, 0, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seed_valid;
    logic       out_ready;
    logic [7:0] seed_v    [N];
    logic [7:0] out_data  [N];
    logic       out_valid [N];
    logic       busy      [N];
`ifdef LFSR_PERIOD_CHECK_EN
    logic       period_done [N];
`endif

    int checks   = 0;
    int failures = 0;

    initial forever #5 clk = ~clk;

    lfsr_prng u_fib (
        .clk (clk), .reset (rst), .seed_valid (seed_valid), .seed (seed_v[0]),
        .out_valid (out_valid[0]), .out_ready (out_ready),
        .out_data (out_data[0]), .busy (busy[0])
`ifdef LFSR_PERIOD_CHECK_EN
        , .period_done (period_done[0])
`endif
    );

    lfsr_prng #(.MODE(1), .GMASK(8'h1D)) u_gal (
        .clk (clk), .reset (rst), .seed_valid (seed_valid), .seed (seed_v[1]),
        .out_valid (out_valid[1]), .out_ready (out_ready),
        .out_data (out_data[1]), .busy (busy[1])
`ifdef LFSR_PERIOD_CHECK_EN
        , .period_done (period_done[1])
`endif
    );

    lfsr_prng #(.WARMUP(3)) u_warm (
        .clk (clk), .reset (rst), .seed_valid (seed_valid), .seed (seed_v[2]),
        .out_valid (out_valid[2]), .out_ready (out_ready),
        .out_data (out_data[2]), .busy (busy[2])
`ifdef LFSR_PERIOD_CHECK_EN
        , .period_done (period_done[2])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One shift as polynomial arithmetic: Fibonacci = double and add the
    // parity of the tapped bits; Galois = multiply by x modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] shift1(input int mode, input logic [7:0] s);
        int t;
        if (mode == 0) begin
            t = (int'(s) * 2) % 256 + ($countones(s & 8'hB8) % 2);
        end else begin
            t = int'(s) * 2;
            if (t >= 256) t = t ^ 'h11D;
        end
        return 8'(t);
    endfunction

    // ------------------------------------------------------------- model
    logic [7:0] m_s      [N] = '{8'h01, 8'h01, 8'h01};
    logic       m_valid  [N] = '{1'b0, 1'b0, 1'b0};
    logic       m_busy   [N] = '{1'b0, 1'b0, 1'b0};
    int         m_left   [N] = '{0, 0, 0};
    logic [7:0] m_loaded [N] = '{8'h01, 8'h01, 8'h01};
    logic       m_pd     [N] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_s[i]      <= 8'h01;
                m_valid[i]  <= 1'b0;
                m_busy[i]   <= 1'b0;
                m_left[i]   <= 0;
                m_loaded[i] <= 8'h01;
                m_pd[i]     <= 1'b0;
            end else begin
                m_pd[i] <= 1'b0;
                if (m_valid[i] && out_ready)
                    $display("tb: inst %0d accepted word %02h", i, m_s[i]);
                if (seed_valid) begin
                    m_s[i]      <= (seed_v[i] == 8'h00) ? 8'h01 : seed_v[i];
                    m_loaded[i] <= (seed_v[i] == 8'h00) ? 8'h01 : seed_v[i];
                    m_left[i]   <= WARM_OF[i];
                    m_busy[i]   <= (WARM_OF[i] > 0);
                    m_valid[i]  <= (WARM_OF[i] == 0);
                end else if (m_busy[i]) begin
                    m_s[i]    <= shift1(MODE_OF[i], m_s[i]);
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_busy[i]  <= 1'b0;
                        m_valid[i] <= 1'b1;
                    end
                end else if (m_valid[i] && out_ready) begin
                    m_s[i]  <= shift1(MODE_OF[i], m_s[i]);
                    m_pd[i] <= (shift1(MODE_OF[i], m_s[i]) == m_loaded[i]);
                end
            end
        end
    end

    // ------------------------------------------------------ compare process
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("inst%0d_valid", i), out_valid[i], m_valid[i]);
            chk($sformatf("inst%0d_busy", i), busy[i], m_busy[i]);
            chk($sformatf("inst%0d_data", i), out_data[i], m_s[i]);
`ifdef LFSR_PERIOD_CHECK_EN
            chk($sformatf("inst%0d_period_done", i), period_done[i], m_pd[i]);
`endif
        end
    end

    // ------------------------------------------------------------ stimulus
    logic [7:0] fib_lit [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    logic [7:0] gal_lit [4] = '{8'h80, 8'h1D, 8'h3A, 8'h74};

    initial begin
        int p0, p1;
        logic [7:0] held;
        seed_valid = 1'b0;
        out_ready  = 1'b0;
        seed_v     = '{8'h01, 8'h80, 8'h01};

        repeat (3) @(negedge clk);
        chk("reset_data", out_data[0], 8'h01);
        chk("reset_valid", out_valid[0], 1'b0);
        chk("reset_busy", busy[2], 1'b0);
        rst = 1'b0;

        // Idle ignores out_ready.
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_valid", out_valid[0], 1'b0);
        chk("idle_data", out_data[0], 8'h01);

        // Seed all three and stream with out_ready held high.
        seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fib_word%0d", k), out_data[0], fib_lit[k]);
            if (k < 4) chk($sformatf("gal_word%0d", k), out_data[1], gal_lit[k]);
            if (k < 3) begin
                chk($sformatf("warm_busy%0d", k), busy[2], 1'b1);
                chk($sformatf("warm_novalid%0d", k), out_valid[2], 1'b0);
            end else if (k == 3) begin
                chk("warm_first_word", out_data[2], 8'h08);
                chk("warm_first_valid", out_valid[2], 1'b1);
            end
            @(negedge clk);
        end

        // First return to the seed, bounded.
        p0 = -1;
        p1 = -1;
        for (int n = 6; n < 300; n++) begin
            if (p0 < 0 && out_data[0] == 8'h01) p0 = n;
            if (p1 < 0 && out_data[1] == 8'h80) p1 = n;
            if (p0 >= 0 && p1 >= 0) break;
            @(negedge clk);
        end
        chk("fib_period", p0, 255);
        chk("gal_period", p1, 255);
`ifdef LFSR_PERIOD_CHECK_EN
        chk("fib_period_done", period_done[0], 1'b1);
`endif

        // Stall pattern 1,0,0,1.
        @(negedge clk);
        held = out_data[0];
        chk("pre_stall_word", held, 8'h02);
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_hold1", out_data[0], held);
        @(negedge clk);
        chk("stall_hold2", out_data[0], held);
        out_ready = 1'b1;
        @(negedge clk);
        chk("after_stall", out_data[0], 8'h04);

        // Seed load during an accept; zero seed on the Galois instance.
        seed_v     = '{8'h5A, 8'h00, 8'hC3};
        seed_valid = 1'b1;
        @(negedge clk);
        chk("reseed_word", out_data[0], 8'h5A);
        chk("zero_seed_gal", out_data[1], 8'h01);
        chk("reseed_warm_busy", busy[2], 1'b1);
        seed_v[0] = 8'h00;
        @(negedge clk);
        chk("zero_seed_fib", out_data[0], 8'h01);
        seed_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of warm-up.
        chk("mid_warm_busy", busy[2], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid[2], 1'b0);
        chk("async_rst_busy", busy[2], 1'b0);
        chk("async_rst_data", out_data[2], 8'h01);
        chk("async_rst_data_fib", out_data[0], 8'h01);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
